// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU core: one instruction per valid/ready handshake,
// executed through IDLE -> EXEC -> WB with carry/zero flags and a register file.
module acc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] acc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADDM  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_LDI   = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hF;

  logic [1:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              wr_acc;
  logic              illegal;
  logic [DATA_W:0]   add_r;
  logic [DATA_W:0]   sub_r;
  logic [DATA_W:0]   addm_r;

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  // Extra MSB of each sum carries the carry-out / borrow.
  assign add_r  = {1'b0, acc_out} + {1'b0, imm_q};
  assign sub_r  = {1'b0, acc_out} - {1'b0, imm_q};
  assign addm_r = {1'b0, acc_out} + {1'b0, m_q};

  always_comb begin
    res     = acc_out;
    res_c   = flag_c;
    wr_acc  = 1'b0;
    illegal = 1'b0;
    case (op_q)
      OP_ADD:   begin res = add_r[DATA_W-1:0];  res_c = add_r[DATA_W];  wr_acc = 1'b1; end
      OP_SUB:   begin res = sub_r[DATA_W-1:0];  res_c = sub_r[DATA_W];  wr_acc = 1'b1; end
      OP_STORE: ;
      OP_LOAD:  begin res = m_q;                                         wr_acc = 1'b1; end
      OP_ADDM:  begin res = addm_r[DATA_W-1:0]; res_c = addm_r[DATA_W]; wr_acc = 1'b1; end
      OP_AND:   begin res = acc_out & imm_q;    res_c = 1'b0;            wr_acc = 1'b1; end
      OP_OR:    begin res = acc_out | imm_q;    res_c = 1'b0;            wr_acc = 1'b1; end
      OP_XOR:   begin res = acc_out ^ imm_q;    res_c = 1'b0;            wr_acc = 1'b1; end
      OP_NOT:   begin res = ~acc_out;           res_c = 1'b0;            wr_acc = 1'b1; end
      OP_SHL:   begin
        res    = {acc_out[DATA_W-2:0], 1'b0};
        res_c  = acc_out[DATA_W-1];
        wr_acc = 1'b1;
      end
      OP_SHR:   begin
        res    = {1'b0, acc_out[DATA_W-1:1]};
        res_c  = acc_out[0];
        wr_acc = 1'b1;
      end
      OP_LDI:   begin res = imm_q;                                       wr_acc = 1'b1; end
      OP_NOP:   ;
      default:  illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      imm_q   <= '0;
      m_q     <= '0;
      acc_out <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q   <= opcode;
            addr_q <= addr;
            imm_q  <= imm;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          m_q   <= mem[addr_q];
          state <= S_WB;
        end
        S_WB: begin
          if (wr_acc) begin
            acc_out <= res;
            flag_z  <= (res == '0);
            flag_c  <= res_c;
          end
          // Write lands before any following EXEC read, so STORE->LOAD sees the new value.
          if (op_q == OP_STORE) mem[addr_q] <= acc_out;
          done  <= 1'b1;
          err   <= illegal;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised accumulator CPU core, the successor to the fixed 4-bit accumulator/FSM CPU. It accepts one instruction per valid/ready handshake and executes it through a three-state FSM (IDLE -> EXEC -> WB). It operates on a DATA_W accumulator and a 2^ADDR_W-entry register file. Compared with the 4-bit core it adds carry/zero flags, memory-operand ALU ops, an immediate load, illegal-opcode reporting and a done strobe. It sits between the top-level pin wrapper and the I/O mux.

Parameters:
DATA_W, 8, accumulator / memory word width (>=2)
ADDR_W, 4, register-file address width; depth = 2**ADDR_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present on opcode/addr/imm
instr_ready  out  1  core can accept an instruction
opcode  in  4  operation code
addr  in  ADDR_W  register-file address
imm  in  DATA_W  immediate operand
acc_out  out  DATA_W  accumulator value (registered)
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
done  out  1  one-cycle pulse, instruction retired
err  out  1  one-cycle pulse with done, illegal opcode
busy  out  1  high in EXEC and WB

Behaviour:
- Reset (async, any state, including mid-instruction):
  - state=IDLE; acc, flags, done, err cleared; all memory words 0.
  - instr_ready=1 after reset deasserts.
  - Any in-flight instruction is dropped.
- IDLE:
  - instr_ready=1.
  - Accept on the clk edge where instr_valid & instr_ready; latch opcode/addr/imm, go to EXEC.
  - Inputs are ignored when not accepted.
- EXEC: register operand M = mem[addr_latched], go to WB.
- WB:
  - Write result, update flags, pulse done for the following cycle, go to IDLE.
- Timing:
  - Accept at edge t0; result visible on acc_out/flags after edge t2, together with done=1.
  - instr_ready is low in EXEC and WB and high again in the done cycle.
  - Throughput is one instruction per 3 cycles.
- Opcodes (R = result, W = DATA_W; all arithmetic modulo 2^W):
  - 0 ADD: R=acc+imm; C=carry out.
  - 1 SUB: R=acc-imm; C=1 if borrow (acc<imm).
  - 2 STORE: mem[addr]=acc; acc and flags unchanged.
  - 3 LOAD: R=M; C unchanged.
  - 4 ADDM: R=acc+M; C=carry out.
  - 5 AND, 6 OR, 7 XOR: R=acc op imm; C=0.
  - 8 NOT: R=~acc; C=0.
  - 9 SHL: R=acc<<1; C=acc[W-1].
  - A SHR: R=acc>>1 (logical); C=acc[0].
  - B LDI: R=imm; C unchanged.
  - F NOP: nothing changes; done pulses.
  - C,D,E illegal: no state change; done and err both pulse.
- Flags:
  - flag_z=(R==0) for every opcode that writes acc.
  - STORE, NOP and illegal opcodes leave Z and C unchanged.
- Memory:
  - Written only by STORE, in WB.
  - A STORE immediately followed by LOAD of the same address returns the stored value (write at WB precedes next EXEC read).
- instr_valid held high continuously: the next instruction is accepted in the done cycle; no instruction is lost or duplicated.
- No backpressure on done/err outputs.

Test Plan:
- Reset mid-EXEC of ADD imm=5 (acc=3) -> acc=0, Z=0, C=0, done never pulses, instr_ready=1 after release.
- DATA_W=8: LDI 0xF0; ADD 0x20 -> acc=0x10, C=1, Z=0, done 3 cycles after each accept; SUB 0x10 -> acc=0x00, Z=1, C=0; SUB 0x01 -> acc=0xFF, C=1.
- STORE addr=7 (acc=0x5A), LDI 0, LOAD addr=7 -> acc=0x5A; ADDM addr=7 -> acc=0xB4, C=0; LOAD of never-written addr=3 -> acc=0, Z=1.
- LDI 0x81; SHL -> acc=0x02, C=1; SHR -> acc=0x01, C=0; NOT -> 0xFE; XOR 0xFE -> 0x00, Z=1, C=0.
- Opcode 0xD with acc=0x33 -> done=1 and err=1 for one cycle, acc=0x33 and flags unchanged; NOP -> done=1, err=0.
- instr_valid held high with 4 back-to-back instructions -> exactly 4 done pulses spaced 3 cycles apart, instr_ready low in EXEC/WB.
